// File: rtl/bar_regs_pkg.sv
// Shared types for the BAR register slave: response codes, FSM states, byte-merge helper.
// Optional per-register write pulses are enabled in the top by BAR_REGS_WR_PULSE_EN.
package bar_regs_pkg;

  localparam int BAR_DW = 32;
  localparam int BAR_AW = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite channel bundle; modport m drives requests, modport s answers them.
// Carries no clock or reset, those travel alongside as plain ports.
interface axi4_lite_if #(
  parameter int DW = 32,
  parameter int AW = 32
);

  logic            awvalid;
  logic            awready;
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            wvalid;
  logic            wready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic            arvalid;
  logic            arready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            rvalid;
  logic            rready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;

  modport m (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport s (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/bar_regs_slave.sv
// AXI4-Lite BAR responder over N_CTRL RW control and N_STAT RO status words; BAR_REGS_WR_PULSE_EN adds wr_pulse_o.
// Latency: B and R valid one cycle after the commit / AR handshake; one write and one read per 2 cycles.
// Backpressure: B and R are held until bready/rready; readies stay low while a response is outstanding.
module bar_regs_slave
  import bar_regs_pkg::*;
#(
  parameter int          N_CTRL   = 8,
  parameter int          N_STAT   = 8,
  parameter logic [31:0] CTRL_RST = 32'h0
) (
  input  logic                     bar_clk,
  input  logic                     bar_reset,
  axi4_lite_if.s                   s,
  input  logic [N_STAT-1:0][31:0]  stat_i,
`ifdef BAR_REGS_WR_PULSE_EN
  output logic [N_CTRL-1:0][31:0]  ctrl_o,
  output logic [N_CTRL-1:0]        wr_pulse_o
`else
  output logic [N_CTRL-1:0][31:0]  ctrl_o
`endif
);

  localparam int N_REGS = N_CTRL + N_STAT;

  wr_state_t   wr_state;
  rd_state_t   rd_state;

  logic        aw_held;
  logic        w_held;
  logic [31:0] aw_idx_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  logic        aw_hs;
  logic        w_hs;
  logic        have_aw;
  logic        have_w;
  logic [31:0] wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  logic [31:0] ar_idx;
  logic [31:0] rd_val;
  logic        rd_err;

  logic        unused_bits;
  assign unused_bits = ^{s.awprot, s.arprot, s.awaddr[1:0], s.araddr[1:0]};

  // Write side: the word used at commit comes from this cycle's handshake or from what is already held.
  always_comb begin
    aw_hs   = s.awvalid && s.awready;
    w_hs    = s.wvalid && s.wready;
    have_aw = aw_held || aw_hs;
    have_w  = w_held || w_hs;
    wr_idx  = aw_hs ? 32'(s.awaddr[BAR_AW-1:2]) : aw_idx_q;
    wr_data = w_hs ? s.wdata : w_data_q;
    wr_strb = w_hs ? s.wstrb : w_strb_q;
  end

  always_comb begin
    ar_idx = 32'(s.araddr[BAR_AW-1:2]);
    rd_val = 32'h0;
    rd_err = 1'b1;
    for (int k = 0; k < N_CTRL; k++) begin
      if (ar_idx == 32'(k)) begin
        rd_val = ctrl_o[k];
        rd_err = 1'b0;
      end
    end
    for (int k = 0; k < N_STAT; k++) begin
      if (ar_idx == 32'(N_CTRL + k)) begin
        rd_val = stat_i[k];
        rd_err = 1'b0;
      end
    end
  end

  always_ff @(posedge bar_clk) begin
    if (bar_reset) begin
      wr_state  <= W_IDLE;
      s.awready <= 1'b0;
      s.wready  <= 1'b0;
      s.bvalid  <= 1'b0;
      s.bresp   <= 2'b00;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_idx_q  <= 32'h0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      ctrl_o    <= {N_CTRL{CTRL_RST}};
`ifdef BAR_REGS_WR_PULSE_EN
      wr_pulse_o <= '0;
`endif
    end else begin
`ifdef BAR_REGS_WR_PULSE_EN
      wr_pulse_o <= '0;
`endif
      case (wr_state)
        W_IDLE: begin
          if (have_aw && have_w) begin
            for (int k = 0; k < N_CTRL; k++) begin
              if (wr_idx == 32'(k)) begin
                ctrl_o[k] <= strb_merge(ctrl_o[k], wr_data, wr_strb);
`ifdef BAR_REGS_WR_PULSE_EN
                wr_pulse_o[k] <= (wr_strb != 4'h0);
`endif
              end
            end
            s.bresp   <= (wr_idx < 32'(N_REGS)) ? RESP_OKAY : RESP_SLVERR;
            s.bvalid  <= 1'b1;
            s.awready <= 1'b0;
            s.wready  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            wr_state  <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held  <= 1'b1;
              aw_idx_q <= wr_idx;
            end
            if (w_hs) begin
              w_held   <= 1'b1;
              w_data_q <= s.wdata;
              w_strb_q <= s.wstrb;
            end
            s.awready <= !have_aw;
            s.wready  <= !have_w;
          end
        end
        W_RESP: begin
          if (s.bready) begin
            s.bvalid  <= 1'b0;
            s.awready <= 1'b1;
            s.wready  <= 1'b1;
            wr_state  <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read side samples ctrl_o before any same-edge write lands, so a colliding read sees the old word.
  always_ff @(posedge bar_clk) begin
    if (bar_reset) begin
      rd_state  <= R_IDLE;
      s.arready <= 1'b0;
      s.rvalid  <= 1'b0;
      s.rdata   <= 32'h0;
      s.rresp   <= 2'b00;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s.arvalid && s.arready) begin
            s.rdata   <= rd_val;
            s.rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            s.rvalid  <= 1'b1;
            s.arready <= 1'b0;
            rd_state  <= R_DATA;
          end else begin
            s.arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s.rready) begin
            s.rvalid  <= 1'b0;
            s.arready <= 1'b1;
            rd_state  <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule
